// File: rtl/tea_byte_loader.sv
// tea_byte_loader: byte-serial front end that keys and feeds the tea_interface core.
// Define TEA_CBC_EN to add CBC chaining around the core; without it blocks pass through as ECB.

module tea_byte_loader #(
    parameter int unsigned WAIT_TIMEOUT = 64,
    parameter logic [63:0] IV = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_key,
    input  logic        s_mode,
    output logic        s_ready,
    output logic [63:0] core_in,
    output logic        core_mode,
    output logic        core_reset,
    output logic        core_write,
    input  logic [63:0] core_out,
    input  logic        core_out_ready,
    output logic [63:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        key_loaded,
    output logic        err
);
    localparam int DATA_W = 64;
    localparam int CNT_W  = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
    // The counter is cleared in WRITE, so WAIT_TIMEOUT-2 in WAIT is the WAIT_TIMEOUT-th cycle after write.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_TIMEOUT - 2);

    typedef enum logic [2:0] {
        COLLECT,
        KEY_HI,
        KEY_LO,
        WRITE,
        WAIT,
        OUT
    } state_t;

    state_t              state;
    logic [3:0]          byte_cnt;
    logic [CNT_W-1:0]    wait_cnt;
    logic                grp_key;
    logic                grp_mode;
    logic                rdy_p0;
    logic [119:0]        key_sr;
    logic [DATA_W-1:0]   key_lo_p0;
    logic [DATA_W-1:0]   last_word;
    logic [DATA_W-1:0]   write_word;
    logic [DATA_W-1:0]   result_word;
    logic                xfer;
    logic                core_edge;

    assign xfer      = s_valid & s_ready;
    assign last_word = {key_sr[55:0], s_data};
    assign core_edge = core_out_ready & ~rdy_p0;

`ifdef TEA_CBC_EN
    logic [DATA_W-1:0] chain;

    assign write_word  = grp_mode ? last_word : (last_word ^ chain);
    assign result_word = core_mode ? (core_out ^ chain) : core_out;
`else
    logic unused_iv;

    assign unused_iv   = ^IV;
    assign write_word  = last_word;
    assign result_word = core_out;
`endif

    // Stage p0: byte assembly; the counter alone decides what is valid, so no reset here
    always_ff @(posedge clk) begin
        if (xfer) begin
            key_sr <= {key_sr[111:0], s_data};
            if (byte_cnt == 4'd15) begin
                key_lo_p0 <= last_word;
            end
        end
    end

    // Control FSM with registered core and stream outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= COLLECT;
            byte_cnt   <= '0;
            wait_cnt   <= '0;
            grp_key    <= 1'b0;
            grp_mode   <= 1'b0;
            rdy_p0     <= 1'b0;
            s_ready    <= 1'b0;
            core_in    <= '0;
            core_mode  <= 1'b0;
            core_reset <= 1'b1;
            core_write <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            key_loaded <= 1'b0;
            err        <= 1'b0;
`ifdef TEA_CBC_EN
            chain      <= IV;
`endif
        end else begin
            err    <= 1'b0;
            rdy_p0 <= core_out_ready;
            case (state)
                COLLECT: begin
                    s_ready    <= 1'b1;
                    core_reset <= 1'b0;
                    if (xfer) begin
                        if (byte_cnt == 4'd0) begin
                            grp_key  <= s_key;
                            grp_mode <= s_mode;
                        end
                        if (grp_key && byte_cnt == 4'd15) begin
                            byte_cnt   <= '0;
                            state      <= KEY_HI;
                            s_ready    <= 1'b0;
                            core_reset <= 1'b1;
                            core_in    <= key_sr[119:56];
                        end else if (!grp_key && byte_cnt == 4'd7) begin
                            byte_cnt <= '0;
                            if (key_loaded) begin
                                state      <= WRITE;
                                s_ready    <= 1'b0;
                                core_write <= 1'b1;
                                core_mode  <= grp_mode;
                                core_in    <= write_word;
                            end else begin
                                err <= 1'b1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                end
                KEY_HI: begin
                    state      <= KEY_LO;
                    core_reset <= 1'b0;
                    core_in    <= key_lo_p0;
                end
                KEY_LO: begin
                    state      <= COLLECT;
                    key_loaded <= 1'b1;
                    s_ready    <= 1'b1;
`ifdef TEA_CBC_EN
                    chain      <= IV;
`endif
                end
                WRITE: begin
                    state      <= WAIT;
                    core_write <= 1'b0;
                    wait_cnt   <= '0;
                end
                WAIT: begin
                    if (core_edge) begin
                        state   <= OUT;
                        m_data  <= result_word;
                        m_valid <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= COLLECT;
                        err     <= 1'b1;
                        s_ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        state   <= COLLECT;
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
`ifdef TEA_CBC_EN
                        // Decrypt chains on the received ciphertext, which core_in still holds
                        chain   <= core_mode ? core_in : m_data;
`endif
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tea_byte_loader.sv
// Bench for tea_byte_loader: a stand-in TEA core plus a scoreboard of expected result blocks.
module tb_tea_byte_loader;
    localparam int WT = 64;
    localparam logic [127:0] KEY = 128'h2b02056806144976775d0e266c287843;
    localparam logic [63:0]  PT  = 64'h74657374206d652e;
    localparam logic [63:0]  CT  = 64'h775d2a6af6ce9209;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_key = 1'b0;
    logic        s_mode = 1'b0;
    logic        s_ready;
    logic [63:0] core_in;
    logic        core_mode;
    logic        core_reset;
    logic        core_write;
    logic [63:0] core_out = 64'h0;
    logic        core_out_ready = 1'b0;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        key_loaded;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
`ifdef TEA_CBC_EN
    logic [63:0] tb_chain = 64'h0;
`endif

    always #5 clk = ~clk;

    tea_byte_loader #(.WAIT_TIMEOUT(WT), .IV(64'h0)) dut (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_key(s_key),
        .s_mode(s_mode), .s_ready(s_ready), .core_in(core_in), .core_mode(core_mode),
        .core_reset(core_reset), .core_write(core_write), .core_out(core_out),
        .core_out_ready(core_out_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .key_loaded(key_loaded), .err(err)
    );

    // Stand-in core: known TEA vector from a table, otherwise an invertible add/subtract of the key.
    function automatic logic [63:0] core_fn(input logic dec, input logic [63:0] x, input logic [127:0] k);
        if (k == KEY && !dec && x == PT) return CT;
        if (k == KEY && dec && x == CT) return PT;
        return dec ? x - (k[127:64] ^ k[63:0]) : x + (k[127:64] ^ k[63:0]);
    endfunction

    logic [63:0] mdl_khi = 64'h0, mdl_klo = 64'h0, mdl_res = 64'h0;
    logic        mdl_lo_pend = 1'b0, mdl_busy = 1'b0, core_hang = 1'b0;
    int          mdl_lat = 0;

    always @(posedge clk) begin
        if (core_reset) begin
            mdl_khi <= core_in;
            mdl_lo_pend <= 1'b1;
        end else if (mdl_lo_pend) begin
            mdl_klo <= core_in;
            mdl_lo_pend <= 1'b0;
        end
        if (core_write) begin
            mdl_res  <= core_fn(core_mode, core_in, {mdl_khi, mdl_klo});
            mdl_busy <= !core_hang;
            mdl_lat  <= 5;
            if (core_hang) core_out_ready <= 1'b0;
        end else if (mdl_busy) begin
            mdl_lat <= mdl_lat - 1;
            // previous result level lingers for a few cycles after the write
            if (mdl_lat == 3) core_out_ready <= 1'b0;
            if (mdl_lat == 0) begin
                core_out <= mdl_res;
                core_out_ready <= 1'b1;
                mdl_busy <= 1'b0;
            end
        end
    end

    int   n_writes = 0, n_mv = 0, n_errp = 0;
    logic rdy_prev = 1'b0;
    time  edge_t = 0;

    always @(negedge clk) begin
        if (core_write === 1'b1) n_writes <= n_writes + 1;
        if (m_valid === 1'b1) n_mv <= n_mv + 1;
        if (err === 1'b1) n_errp <= n_errp + 1;
        if (core_out_ready && !rdy_prev) edge_t <= $time;
        rdy_prev <= core_out_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic k, input logic md);
        int g = 0;
        s_data = b; s_key = k; s_mode = md; s_valid = 1'b1;
        while (s_ready !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (s_ready !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL send_byte s_ready=%b want 1 within 200 cycles", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Later bytes carry inverted s_key/s_mode, which the loader must ignore.
    task automatic send_group(input logic [127:0] v, input int n, input logic k, input logic md);
        for (int i = 0; i < n; i++)
            send_byte(v[127-8*i -: 8], (i == 0) ? k : ~k, (i == 0) ? md : ~md);
    endtask

    function automatic logic [63:0] exp_of(input logic [63:0] blk, input logic md);
`ifdef TEA_CBC_EN
        return md ? (core_fn(1'b1, blk, KEY) ^ tb_chain) : core_fn(1'b0, blk ^ tb_chain, KEY);
`else
        return core_fn(md, blk, KEY);
`endif
    endfunction

    task automatic wait_result(input int stall);
        int g = 0;
        logic [63:0] want, held;
        m_ready = (stall == 0);
        while (m_valid !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        want = exp_q.pop_front();
        n_vec++;
        if (m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL result_timeout m_valid=%b want 1 within 200 cycles", m_valid);
            m_ready = 1'b0;
            return;
        end
        if (m_data !== want) begin
            n_err++;
            $display("FAIL m_data got %h want %h", m_data, want);
        end
        n_vec++;
        if ($time - edge_t != 10) begin
            n_err++;
            $display("FAIL edge_to_valid got %0t want 10", $time - edge_t);
        end
        held = m_data;
        for (int i = 0; i < stall; i++) begin
            n_vec++;
            if (m_valid !== 1'b1 || m_data !== held || s_ready !== 1'b0) begin
                n_err++;
                $display("FAIL out_hold cyc%0d m_valid=%b m_data=%h s_ready=%b want 1 %h 0", i, m_valid, m_data, s_ready, held);
            end
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL after_accept m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
        end
        m_ready = 1'b0;
    endtask

    task automatic run_block(input logic [63:0] blk, input logic md, input int stall, input logic [63:0] expv);
        logic [63:0] cin;
`ifdef TEA_CBC_EN
        cin = md ? blk : (blk ^ tb_chain);
`else
        cin = blk;
`endif
        exp_q.push_back(expv);
        send_group({blk, 64'h0}, 8, 1'b0, md);
        n_vec++;
        if (core_write !== 1'b1 || core_in !== cin || core_mode !== md) begin
            n_err++;
            $display("FAIL write core_write=%b core_in=%h core_mode=%b want 1 %h %b", core_write, core_in, core_mode, cin, md);
        end
        wait_result(stall);
`ifdef TEA_CBC_EN
        tb_chain = md ? blk : expv;
`endif
    endtask

    task automatic test_reset;
        reset_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({s_ready, core_reset, core_write, m_valid, key_loaded, err, core_mode} !== 7'b0100000) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want 0100000", {s_ready, core_reset, core_write, m_valid, key_loaded, err, core_mode});
        end
        n_vec++;
        if (core_in !== 64'h0 || m_data !== 64'h0) begin
            n_err++;
            $display("FAIL reset_data core_in=%h m_data=%h want 0 0", core_in, m_data);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (s_ready !== 1'b1 || core_reset !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release s_ready=%b core_reset=%b want 1 0", s_ready, core_reset);
        end
`ifdef TEA_CBC_EN
        tb_chain = 64'h0;
`endif
    endtask

    task automatic test_no_key;
        int w0, v0, e0;
        w0 = n_writes; v0 = n_mv; e0 = n_errp;
        send_group({PT, 64'h0}, 8, 1'b0, 1'b0);
        n_vec++;
        if (err !== 1'b1 || s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL nokey_err err=%b s_ready=%b want 1 1", err, s_ready);
        end
        @(negedge clk);
        n_vec++;
        if (err !== 1'b0 || s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL nokey_pulse err=%b s_ready=%b want 0 1", err, s_ready);
        end
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (n_writes != w0 || n_mv != v0 || n_errp != e0 + 1) begin
            n_err++;
            $display("FAIL nokey_counts writes=%0d mvalid=%0d errs=%0d want %0d %0d %0d", n_writes, n_mv, n_errp, w0, v0, e0 + 1);
        end
    endtask

    task automatic test_key_load;
        send_group(KEY, 16, 1'b1, 1'b0);
        n_vec++;
        if (core_reset !== 1'b1 || core_in !== KEY[127:64] || s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL key_hi core_reset=%b core_in=%h s_ready=%b want 1 %h 0", core_reset, core_in, s_ready, KEY[127:64]);
        end
        @(negedge clk);
        n_vec++;
        if (core_reset !== 1'b0 || core_in !== KEY[63:0]) begin
            n_err++;
            $display("FAIL key_lo core_reset=%b core_in=%h want 0 %h", core_reset, core_in, KEY[63:0]);
        end
        @(negedge clk);
        n_vec++;
        if (key_loaded !== 1'b1 || s_ready !== 1'b1 || {mdl_khi, mdl_klo} !== KEY) begin
            n_err++;
            $display("FAIL key_done key_loaded=%b s_ready=%b core_key=%h want 1 1 %h", key_loaded, s_ready, {mdl_khi, mdl_klo}, KEY);
        end
`ifdef TEA_CBC_EN
        tb_chain = 64'h0;
`endif
    endtask

    task automatic test_encrypt;
        run_block(PT, 1'b0, 0, exp_of(PT, 1'b0));
    endtask

    task automatic test_decrypt;
        run_block(CT, 1'b1, 0, exp_of(CT, 1'b1));
    endtask

    task automatic test_backpressure;
        run_block(PT, 1'b0, 5, exp_of(PT, 1'b0));
    endtask

    task automatic test_timeout;
        int g = 0;
        int v0;
        time t_w;
        core_hang = 1'b1;
        v0 = n_mv;
        send_group({PT, 64'h0}, 8, 1'b0, 1'b0);
        t_w = $time;
        n_vec++;
        if (core_write !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_write core_write=%b want 1", core_write);
        end
        while (err !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        n_vec++;
        if (err !== 1'b1 || ($time - t_w) != WT * 10) begin
            n_err++;
            $display("FAIL timeout_err err=%b delay=%0t want 1 %0d", err, $time - t_w, WT * 10);
        end
        n_vec++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_state s_ready=%b m_valid=%b want 1 0", s_ready, m_valid);
        end
        #1;
        n_vec++;
        if (n_mv != v0) begin
            n_err++;
            $display("FAIL timeout_mvalid count=%0d want %0d", n_mv, v0);
        end
        core_hang = 1'b0;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) send_byte(KEY[127-8*i -: 8], 1'b1, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (key_loaded !== 1'b0 || core_reset !== 1'b1 || s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid key_loaded=%b core_reset=%b s_ready=%b want 0 1 0", key_loaded, core_reset, s_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
`ifdef TEA_CBC_EN
        tb_chain = 64'h0;
`endif
        test_key_load();
        run_block(PT, 1'b0, 0, exp_of(PT, 1'b0));
    endtask

`ifdef TEA_CBC_EN
    task automatic test_cbc;
        logic [63:0] c2;
        c2 = core_fn(1'b0, PT ^ CT, KEY);
        test_key_load();
        run_block(PT, 1'b0, 0, CT);
        run_block(PT, 1'b0, 0, c2);
        test_key_load();
        run_block(CT, 1'b1, 0, PT);
        run_block(c2, 1'b1, 0, PT);
    endtask
`endif

    initial begin
        test_reset();
        test_no_key();
        test_key_load();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_timeout();
        test_key_load();
        test_encrypt();
        test_reset_mid();
`ifdef TEA_CBC_EN
        test_cbc();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
